// File: rtl/cla_family_pkg.sv
// ============================================================================
//  Module   : cla_family_pkg
//  Brief    : Shared constants for the cla_family arithmetic blocks
//             (digit width and FSM state encodings).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cla_family_pkg;

  // Width of one carry-lookahead digit
  localparam int DIGIT_W = 4;

  // Two-state sequencer encodings shared by the serial blocks
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/carry_lookahead_4bit.sv
// ============================================================================
//  Module   : carry_lookahead_4bit
//  Brief    : Purely combinational 4-bit adder with all internal carries
//             produced by two-level generate/propagate lookahead.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module carry_lookahead_4bit
  import cla_family_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_x,
  input  logic [DIGIT_W-1:0] i_y,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_sum,
  output logic               o_cout
);

  logic [DIGIT_W-1:0] w_g;
  logic [DIGIT_W-1:0] w_p;
  logic [DIGIT_W:0]   w_c;

  // Bit generate/propagate, then every carry expanded directly from c0
  always_comb begin
    w_g    = i_x & i_y;
    w_p    = i_x ^ i_y;
    w_c[0] = i_cin;
    w_c[1] = w_g[0] | (w_p[0] & i_cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
    o_sum  = w_p ^ w_c[DIGIT_W-1:0];
    o_cout = w_c[DIGIT_W];
  end

endmodule

`default_nettype wire

// File: rtl/cla_serial_subtractor.sv
// ============================================================================
//  Module   : cla_serial_subtractor
//  Brief    : Digit-serial two's-complement subtractor, D = A - B - Bin,
//             one 4-bit lookahead digit per clock with start/busy/done.
//             WIDTH must be a multiple of 4 and at least 4.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_serial_subtractor
  import cla_family_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  // Counter is at least one bit wide so WIDTH=4 still has a legal vector
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIGITS - 1);

  logic [0:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_diff;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_d;
  logic               r_bout;
  logic               r_v;
  logic               r_z;

  logic [DIGIT_W-1:0] w_x;
  logic [DIGIT_W-1:0] w_y;
  logic [DIGIT_W-1:0] w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_diff_next;
  logic               w_last;

  // Select the current digit; subtraction is A + ~B + ~Bin, so Y is inverted
  always_comb begin
    w_x    = r_a[int'(r_cnt)*DIGIT_W +: DIGIT_W];
    w_y    = ~r_b[int'(r_cnt)*DIGIT_W +: DIGIT_W];
    w_last = (r_cnt == C_LAST);
  end

  carry_lookahead_4bit u_digit (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Difference with the current digit merged in, so the final edge can
  // publish a complete result without waiting a cycle
  always_comb begin
    w_diff_next = r_diff;
    w_diff_next[int'(r_cnt)*DIGIT_W +: DIGIT_W] = w_sum;
  end

  // Sequencer: capture on start, one digit per RUN edge, publish on last digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_a     <= A;
          r_b     <= B;
          r_carry <= ~Bin;
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
      end else begin
        r_diff  <= w_diff_next;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_d     <= w_diff_next;
          r_bout  <= ~w_cout;
          r_v     <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                     (w_diff_next[WIDTH-1] != r_a[WIDTH-1]);
          r_z     <= (w_diff_next == '0);
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign D    = r_d;
  assign Bout = r_bout;
  assign V    = r_v;
  assign Z    = r_z;

endmodule

`default_nettype wire

// File: tb/tb_cla_serial_subtractor.sv
// ============================================================================
//  Module   : tb_cla_serial_subtractor
//  Brief    : Directed and swept self-checking bench for the digit-serial
//             subtractor at WIDTH=16.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        busy;
  logic        done;
  logic [15:0] D;
  logic        Bout;
  logic        V;
  logic        Z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_serial_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .V     (V),
    .Z     (Z)
  );

  // Called at a negedge with the DUT idle. Issues one operation, scrambles the
  // inputs after acceptance, and returns at the negedge of the done cycle.
  // lat counts rising edges from the accepting edge to the one raising done.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic bin, output int lat, output logic run_ok);
    logic [15:0] d_hold;
    d_hold = D;
    run_ok = 1'b1;
    start  = 1'b1;
    A      = a;
    B      = b;
    Bin    = bin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A     = 16'($urandom);
    B     = 16'($urandom);
    Bin   = ~bin;
    if (busy !== 1'b1 || done !== 1'b0 || D !== d_hold) run_ok = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done === 1'b1) break;
      if (busy !== 1'b1 || D !== d_hold) run_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 16'hFFFF; B = 16'h0001; Bin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (D !== 16'h0000) begin errors++; $display("FAIL reset_D got %h want 0000", D); end
    checks++; if ({Bout, V, Z} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {Bout, V, Z}); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int   lat;
    logic ok;
    do_op(16'h1234, 16'h0234, 1'b0, lat, ok);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_busy_run got %b want 1", ok); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    checks++; if (D !== 16'h1000) begin errors++; $display("FAIL basic_D got %h want 1000", D); end
    checks++; if ({Bout, V, Z} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b want 000", {Bout, V, Z}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (D !== 16'h1000) begin errors++; $display("FAIL basic_D_hold got %h want 1000", D); end
  endtask

  task automatic test_borrow_overflow();
    int   lat;
    logic ok;
    do_op(16'h0000, 16'h0001, 1'b0, lat, ok);
    checks++; if (D !== 16'hFFFF) begin errors++; $display("FAIL under_D got %h want ffff", D); end
    checks++; if ({Bout, V, Z} !== 3'b100) begin errors++; $display("FAIL under_flags got %b want 100", {Bout, V, Z}); end
    do_op(16'h7FFF, 16'hFFFF, 1'b0, lat, ok);
    checks++; if (D !== 16'h8000) begin errors++; $display("FAIL posovf_D got %h want 8000", D); end
    checks++; if ({Bout, V, Z} !== 3'b110) begin errors++; $display("FAIL posovf_flags got %b want 110", {Bout, V, Z}); end
    do_op(16'h8000, 16'h0001, 1'b0, lat, ok);
    checks++; if (D !== 16'h7FFF) begin errors++; $display("FAIL negovf_D got %h want 7fff", D); end
    checks++; if ({Bout, V, Z} !== 3'b010) begin errors++; $display("FAIL negovf_flags got %b want 010", {Bout, V, Z}); end
  endtask

  task automatic test_zero();
    int   lat;
    logic ok;
    do_op(16'h0005, 16'h0005, 1'b0, lat, ok);
    checks++; if (D !== 16'h0000) begin errors++; $display("FAIL zero_D got %h want 0000", D); end
    checks++; if ({Bout, V, Z} !== 3'b001) begin errors++; $display("FAIL zero_flags got %b want 001", {Bout, V, Z}); end
    do_op(16'h0005, 16'h0005, 1'b1, lat, ok);
    checks++; if (D !== 16'hFFFF) begin errors++; $display("FAIL bin_D got %h want ffff", D); end
    checks++; if ({Bout, V, Z} !== 3'b100) begin errors++; $display("FAIL bin_flags got %b want 100", {Bout, V, Z}); end
  endtask

  task automatic test_ignore_start_and_back_to_back();
    int   edges;
    int   lat;
    int   extra;
    logic ok;
    start = 1'b1; A = 16'h00F0; B = 16'h000F; Bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Second request while busy must be dropped
    start = 1'b1; A = 16'hFFFF; B = 16'h0000; Bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (edges < 20 && done !== 1'b1) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++; if (edges !== 4) begin errors++; $display("FAIL ignore_latency got %0d want 4", edges); end
    checks++; if (D !== 16'h00E1) begin errors++; $display("FAIL ignore_D got %h want 00e1", D); end
    // Start in the done cycle is accepted immediately
    do_op(16'h0100, 16'h0001, 1'b0, lat, ok);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", lat); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_run got %b want 1", ok); end
    checks++; if (D !== 16'h00FF) begin errors++; $display("FAIL b2b_D got %h want 00ff", D); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_abort();
    int   lat;
    int   extra;
    logic ok;
    // Leave a nonzero result with V set so the clear is observable
    do_op(16'h8000, 16'h0001, 1'b0, lat, ok);
    @(negedge clk);
    start = 1'b1; A = 16'h1111; B = 16'h0001; Bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_busy_done got %b want 00", {busy, done}); end
    checks++; if (D !== 16'h0000) begin errors++; $display("FAIL abort_D got %h want 0000", D); end
    checks++; if ({Bout, V, Z} !== 3'b000) begin errors++; $display("FAIL abort_flags got %b want 000", {Bout, V, Z}); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", extra); end
  endtask

  task automatic test_random();
    int          lat;
    logic        ok;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [16:0] ref_full;
    logic [15:0] ref_d;
    logic        ref_v;
    for (int i = 0; i < 10000; i++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      bin = 1'($urandom);
      ref_full = {1'b0, a} - {1'b0, b} - {16'h0, bin};
      ref_d    = ref_full[15:0];
      ref_v    = (a[15] != b[15]) && (ref_d[15] != a[15]);
      do_op(a, b, bin, lat, ok);
      checks++; if (lat !== 4 || ok !== 1'b1) begin errors++; $display("FAIL rnd_timing a=%h b=%h got lat=%0d ok=%b want 4 1", a, b, lat, ok); end
      checks++; if (D !== ref_d) begin errors++; $display("FAIL rnd_D a=%h b=%h bin=%b got %h want %h", a, b, bin, D, ref_d); end
      checks++; if ({Bout, V, Z} !== {ref_full[16], ref_v, ref_d == 16'h0}) begin
        errors++;
        $display("FAIL rnd_flags a=%h b=%h bin=%b got %b want %b", a, b, bin, {Bout, V, Z}, {ref_full[16], ref_v, ref_d == 16'h0});
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_borrow_overflow();
    test_zero();
    test_ignore_start_and_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
